// File: rtl/comparador_serie.sv
// Multi-cycle N-bit magnitude comparator, W bits per cycle, MSB chunk first.
// Optional two's-complement ordering of the MSB chunk via COMPARADOR_SIGNED_EN.
module comparador_serie #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic                   signed_in,
  input  logic [N-1:0]           a_in,
  input  logic [N-1:0]           b_in,
  output logic                   ready_out,
  output logic                   valid_out,
  output logic                   gt_out,
  output logic                   lt_out,
  output logic                   eq_out,
  output logic [$clog2(N/W):0]   steps_out
);

  localparam int CHUNKS = N / W;
  localparam int SW = $clog2(CHUNKS) + 1;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          gt_q, gt_d;
  logic          lt_q, lt_d;
  logic          eq_q, eq_d;
  logic [SW-1:0] steps_q, steps_d;

  logic [W-1:0]  a_ch [CHUNKS];
  logic [W-1:0]  b_ch [CHUNKS];
  logic [W-1:0]  ca, cb;
  logic [W-1:0]  flip;

  for (genvar i = 0; i < CHUNKS; i++) begin : g_ch
    assign a_ch[i] = a_q[i*W +: W];
    assign b_ch[i] = b_q[i*W +: W];
  end

`ifdef COMPARADOR_SIGNED_EN
  logic sgn_q, sgn_d;

  // Inverting the sign bit maps signed order onto unsigned order
  always_comb begin
    flip = '0;
    flip[W-1] = sgn_q && (idx_q == IW'(CHUNKS - 1));
  end
`else
  logic unused_sgn;

  assign unused_sgn = signed_in;
  assign flip = '0;
`endif

  assign ca = a_ch[idx_q] ^ flip;
  assign cb = b_ch[idx_q] ^ flip;

  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    steps_d = steps_q;
`ifdef COMPARADOR_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    unique case (state)
      IDLE: begin
        if (start_in) begin
          a_d     = a_in;
          b_d     = b_in;
`ifdef COMPARADOR_SIGNED_EN
          sgn_d   = signed_in;
`endif
          idx_d   = IW'(CHUNKS - 1);
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          steps_d = '0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        steps_d = steps_q + SW'(1);
        if (ca > cb) begin
          gt_d    = 1'b1;
          state_d = DONE;
        end else if (ca < cb) begin
          lt_d    = 1'b1;
          state_d = DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      steps_q <= '0;
    end else begin
      state   <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      steps_q <= steps_d;
    end
  end

`ifdef COMPARADOR_SIGNED_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) sgn_q <= 1'b0;
    else        sgn_q <= sgn_d;
  end
`endif

  assign ready_out = (state == IDLE);
  assign valid_out = (state == DONE);
  assign gt_out    = gt_q;
  assign lt_out    = lt_q;
  assign eq_out    = eq_q;
  assign steps_out = steps_q;

endmodule

// File: tb/tb_comparador_serie.sv
// Randomised and directed bench for comparador_serie (N=8, W=2)
// against an arithmetic reference model.
module tb_comparador_serie;

  localparam int N = 8;
  localparam int W = 2;
  localparam int CH = N / W;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic         start_in = 1'b0;
  logic         signed_in = 1'b0;
  logic [N-1:0] a_in = '0;
  logic [N-1:0] b_in = '0;
  logic         ready_out, valid_out;
  logic         gt_out, lt_out, eq_out;
  logic [2:0]   steps_out;

  int passed = 0;
  int total = 0;

  comparador_serie #(.N(N), .W(W)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start_in  (start_in),
    .signed_in (signed_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .gt_out    (gt_out),
    .lt_out    (lt_out),
    .eq_out    (eq_out),
    .steps_out (steps_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: ordering from full-width arithmetic, k from first differing chunk
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit s, output int k, output bit gt,
                       output bit lt, output bit eq);
    int av, bv;
    k = CH;
    for (int i = CH - 1; i >= 0; i--) begin
      if (((a >> (i * W)) & 8'h3) != ((b >> (i * W)) & 8'h3)) begin
        k = CH - i;
        break;
      end
    end
    av = int'(a);
    bv = int'(b);
`ifdef COMPARADOR_SIGNED_EN
    if (s) begin
      av = int'($signed(a));
      bv = int'($signed(b));
    end
`else
    if (s) av = int'(a);
`endif
    gt = av > bv;
    lt = av < bv;
    eq = av == bv;
  endtask

  // Caller sits between edges; returns #1 after Ek (chain) or Ek+1
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit s, input bit hold, input bit chain);
    int k, c, acc;
    bit gt, lt, eq;
    model(a, b, s, k, gt, lt, eq);
    a_in = a;
    b_in = b;
    signed_in = s;
    start_in = 1'b1;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in);
      #1;
      if (!ready_out) begin
        acc = 1;
        break;
      end
    end
    chk("accept", 32'(acc), 32'd1);
    chk("cleared", {28'd0, gt_out, lt_out, eq_out, valid_out}, 32'd0);
    chk("steps_clr", 32'(steps_out), 32'd0);
    if (!hold) start_in = 1'b0;
    if (hold) begin
      a_in = 8'hFF;
      b_in = 8'h00;
    end else begin
      a_in = N'($urandom);
      b_in = N'($urandom);
    end
    signed_in = ~s;
    c = 0;
    for (int i = 1; i <= CH + 2; i++) begin
      @(posedge clk_in);
      #1;
      if (valid_out) begin
        c = i;
        break;
      end
    end
    start_in = 1'b0;
    chk("latency", 32'(c), 32'(k));
    chk("result", {29'd0, gt_out, lt_out, eq_out}, {29'd0, gt, lt, eq});
    chk("steps", 32'(steps_out), 32'(k));
    chk("ready_busy", 32'(ready_out), 32'd0);
    if (!chain) begin
      @(posedge clk_in);
      #1;
      chk("pulse_end", {30'd0, valid_out, ready_out}, 32'd1);
      chk("hold", {29'd0, gt_out, lt_out, eq_out}, {29'd0, gt, lt, eq});
    end
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    #3;
    chk("rst_out", {26'd0, ready_out, valid_out, gt_out, lt_out, eq_out,
        steps_out == 3'd0}, 32'b100001);
    @(negedge clk_in);
    rst_in = 1'b0;

    do_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    do_op(8'h80, 8'h7F, 1'b0, 1'b0, 1'b0);
    do_op(8'h35, 8'h36, 1'b0, 1'b0, 1'b1);
    do_op(8'hC0, 8'h40, 1'b0, 1'b0, 1'b0);
    do_op(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in);
      #1;
      chk("no_extra_valid", 32'(valid_out), 32'd0);
    end

    // Abandon an equal compare between E2 and E3
    @(negedge clk_in);
    a_in = 8'h5A;
    b_in = 8'h5A;
    start_in = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    chk("async_rst", {26'd0, ready_out, valid_out, gt_out, lt_out, eq_out,
        steps_out == 3'd0}, 32'b100001);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in);
      #1;
      chk("rst_no_valid", 32'(valid_out), 32'd0);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    do_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if (i % 5 == 0) rb = ra;
      if (i % 5 == 1) rb = ra ^ N'(1 << $urandom_range(N - 1));
      do_op(ra, rb, 1'($urandom), 1'b0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
